cw_deserializer: RTL and testbench

CW_DESERIALIZER -- requirements
Module: cw_deserializer

---
 rtl/cw_deserializer.sv | 126 ++++++++++++
 tb/tb_cw_deserializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cw_deserializer.sv
// Collects IN_W-bit beats LSB-first into an N_V-bit codeword, with one held word of backpressure slack.
// Optional delivery counter: define CW_DESER_FRAME_CNT_EN to add the frame_cnt_o port.
module cw_deserializer #(
   parameter int unsigned N_V  = 44,
   parameter int unsigned IN_W = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [IN_W-1:0] in_data_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic            flush_i,
   output logic [N_V-1:0]  cw_o,
   output logic            cw_valid_o,
   input  logic            cw_ready_i
`ifdef CW_DESER_FRAME_CNT_EN
   ,
   output logic [15:0]     frame_cnt_o
`endif
);

   localparam int unsigned BEATS = N_V / IN_W;
   localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned IdxW  = (N_V > 1) ? $clog2(N_V) : 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

   typedef enum logic {StFill, StHold} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [N_V-1:0]  asm_q;
   logic [N_V-1:0]  cw_q;
   logic            cw_valid_q;
   logic            in_ready_q;

   logic [N_V-1:0]  full_w;
   logic [IdxW-1:0] base_w;
   logic            accept_w;
   logic            deliver_w;

   assign accept_w  = in_valid_i && in_ready_q;
   assign deliver_w = cw_valid_q && cw_ready_i;

   // Assembly register with the current beat merged in at its slot.
   always_comb begin
      base_w = IdxW'(cnt_q) * IdxW'(IN_W);
      full_w = asm_q;
      full_w[base_w +: IN_W] = in_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StFill;
         cnt_q      <= '0;
         asm_q      <= '0;
         cw_q       <= '0;
         cw_valid_q <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         if (deliver_w) begin
            cw_valid_q <= 1'b0;
         end
         unique case (state_q)
            StFill: begin
               in_ready_q <= 1'b1;
               if (flush_i) begin
                  cnt_q <= '0;
                  asm_q <= '0;
               end else if (accept_w) begin
                  if (cnt_q == LastBeat) begin
                     cnt_q <= '0;
                     if (!cw_valid_q || cw_ready_i) begin
                        cw_q       <= full_w;
                        cw_valid_q <= 1'b1;
                        asm_q      <= '0;
                     end else begin
                        asm_q      <= full_w;
                        state_q    <= StHold;
                        in_ready_q <= 1'b0;
                     end
                  end else begin
                     asm_q <= full_w;
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            StHold: begin
               if (flush_i) begin
                  asm_q      <= '0;
                  state_q    <= StFill;
                  in_ready_q <= 1'b1;
               end else if (deliver_w) begin
                  // Held word replaces the delivered one with no gap in cw_valid.
                  cw_q       <= asm_q;
                  cw_valid_q <= 1'b1;
                  asm_q      <= '0;
                  state_q    <= StFill;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StFill;
            end
         endcase
      end
   end

   assign in_ready_o = in_ready_q;
   assign cw_o       = cw_q;
   assign cw_valid_o = cw_valid_q;

`ifdef CW_DESER_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frame_cnt_q <= '0;
      end else if (deliver_w) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_cw_deserializer.sv
// Directed bench for cw_deserializer: queue-based word model checked every cycle, plus literal checks.
module tb_cw_deserializer;

   localparam int unsigned N_V   = 44;
   localparam int unsigned IN_W  = 4;
   localparam int unsigned BEATS = N_V / IN_W;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [IN_W-1:0] in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_ready_o;
   logic            flush = 1'b0;
   logic [N_V-1:0]  cw_o;
   logic            cw_valid_o;
   logic            cw_ready = 1'b1;
`ifdef CW_DESER_FRAME_CNT_EN
   logic [15:0]     frame_cnt_o;
`endif

   cw_deserializer #(.N_V(N_V), .IN_W(IN_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready_o),
      .flush_i     (flush),
      .cw_o        (cw_o),
      .cw_valid_o  (cw_valid_o),
      .cw_ready_i  (cw_ready)
`ifdef CW_DESER_FRAME_CNT_EN
      ,
      .frame_cnt_o (frame_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: complete words waiting for delivery (front = on cw, second = held) and partial beats.
   logic [N_V-1:0]  exp_q[$];
   logic [IN_W-1:0] part[$];
   bit              m_rdy;
   int unsigned     m_frames;
   bit              m_dlv, m_acc, m_held;

   function automatic logic [N_V-1:0] pack_part();
      logic [N_V-1:0] w = '0;
      for (int k = 0; k < int'(BEATS); k++) w[k*IN_W +: IN_W] = part[k];
      return w;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         part.delete();
         m_rdy    = 1'b0;
         m_frames = 0;
      end else begin
         m_dlv  = (exp_q.size() > 0) && cw_ready;
         m_acc  = in_valid && m_rdy;
         m_held = (exp_q.size() == 2);
         if (m_dlv) begin
            void'(exp_q.pop_front());
            m_frames++;
         end
         if (flush) begin
            part.delete();
            if (m_held) void'(exp_q.pop_back());
         end else if (m_acc) begin
            part.push_back(in_data);
            if (part.size() == BEATS) begin
               exp_q.push_back(pack_part());
               part.delete();
            end
         end
         m_rdy = (exp_q.size() < 2);
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 64'(in_ready_o), 64'(m_rdy));
      chk("cw_valid", 64'(cw_valid_o), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("cw", 64'(cw_o), 64'(exp_q[0]));
`ifdef CW_DESER_FRAME_CNT_EN
      chk("frame_cnt", 64'(frame_cnt_o), 64'(m_frames % 65536));
`endif
   end

   // Offer one beat; returns at the negedge after it was accepted, in_valid left high.
   task automatic send(input logic [IN_W-1:0] d);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int n = 0; n < 200; n++) begin
         acc = in_ready_o;
         @(negedge clk);
         if (acc) break;
      end
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: beat %h not accepted, expected acceptance", d);
      end
   endtask

   initial begin
      #1;
      chk("rst_cw", 64'(cw_o), 64'h0);
      chk("rst_valid", 64'(cw_valid_o), 64'h0);
      chk("rst_ready", 64'(in_ready_o), 64'h0);
      @(negedge clk);
      #3 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(in_ready_o), 64'h1);

      // Back-to-back basic word
      for (int i = 1; i <= 11; i++) send(IN_W'(i));
      in_valid = 1'b0;
      chk("t1_valid", 64'(cw_valid_o), 64'h1);
      chk("t1_cw", 64'(cw_o), 64'hBA987654321);
      @(negedge clk);
      chk("t1_one_cycle", 64'(cw_valid_o), 64'h0);

      // Backpressure: two words, second held
      cw_ready = 1'b0;
      for (int i = 0; i < 22; i++) send(IN_W'(i % 16));
      in_valid = 1'b0;
      chk("t2_ready_low", 64'(in_ready_o), 64'h0);
      repeat (3) @(negedge clk);
      chk("t2_hold_cw", 64'(cw_o), 64'hA9876543210);
      cw_ready = 1'b1;
      @(negedge clk);
      chk("t2_second_cw", 64'(cw_o), 64'h543210FEDCB);
      chk("t2_second_valid", 64'(cw_valid_o), 64'h1);
      @(negedge clk);
      chk("t2_drained", 64'(cw_valid_o), 64'h0);

      // Flush after 5 beats, beat on the flush cycle dropped
      for (int i = 0; i < 5; i++) send(4'h3);
      in_data = 4'h7;
      flush   = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      for (int i = 0; i < 11; i++) send(4'hF);
      in_valid = 1'b0;
      chk("t3_cw", 64'(cw_o), 64'hFFFFFFFFFFF);
      chk("t3_valid", 64'(cw_valid_o), 64'h1);
      @(negedge clk);

      // Flush coincident with the last beat
      for (int i = 0; i < 10; i++) send(4'h9);
      flush = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("t4_no_word", 64'(cw_valid_o), 64'h0);
      for (int i = 0; i < 11; i++) send(4'h6);
      in_valid = 1'b0;
      chk("t4_cw", 64'(cw_o), 64'h66666666666);
      @(negedge clk);

      // Flush in HOLD drops only the held word
      cw_ready = 1'b0;
      for (int i = 0; i < 22; i++) send(IN_W'(i % 16));
      in_valid = 1'b0;
      flush    = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("t5_ready_back", 64'(in_ready_o), 64'h1);
      chk("t5_cw_kept", 64'(cw_o), 64'hA9876543210);
      cw_ready = 1'b1;
      @(negedge clk);
      chk("t5_held_dropped", 64'(cw_valid_o), 64'h0);
      for (int i = 0; i < 11; i++) send(4'hE);
      in_valid = 1'b0;
      chk("t5_cw", 64'(cw_o), 64'hEEEEEEEEEEE);
      @(negedge clk);

      // Asynchronous reset mid-codeword with a word pending
      cw_ready = 1'b0;
      for (int i = 0; i < 11; i++) send(4'h1);
      for (int i = 0; i < 7; i++) send(4'h2);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(cw_valid_o), 64'h0);
      chk("t6_rst_cw", 64'(cw_o), 64'h0);
      chk("t6_rst_ready", 64'(in_ready_o), 64'h0);
      #4 rst = 1'b0;
      @(negedge clk);
      chk("t6_ready_still_low", 64'(in_ready_o), 64'h0);
      @(negedge clk);
      chk("t6_ready_up", 64'(in_ready_o), 64'h1);
      cw_ready = 1'b1;
      for (int i = 0; i < 11; i++) send(4'h5);
      in_valid = 1'b0;
      chk("t6_cw", 64'(cw_o), 64'h55555555555);
      @(negedge clk);
      chk("t6_drained", 64'(cw_valid_o), 64'h0);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
